clk_ratio_sel: RTL and testbench

Runtime clock-ratio selector sitting directly downstream of the osc_clk clock divider. It consumes the eight divider enables (divide-by-1 through divide-by-8) and drives a single selected clock enable, `sel_clk_en`, to the logic that runs off osc_clk. It switches between ratios without glitches under a request/acknowledge handshake:

- drain the current ratio's pulse;
- hold enables off for a guard window;
- resume on the first pulse of the new ratio.

It also keeps a running count of delivered enable pulses.

---
 rtl/clk_ratio_sel_if.sv | 22 ++
 rtl/clk_ratio_sel.sv | 109 ++++++++++
 tb/tb_clk_ratio_sel.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/clk_ratio_sel_if.sv
// Handshake and enable bundle between the ratio selector and its controller.
// The master side drives divider enables and switch requests; the slave side is the selector.
interface clk_ratio_sel_if;
   logic [7:0]  clk_en_vec;
   logic        ratio_req;
   logic [2:0]  ratio_new;
   logic        ratio_ack;
   logic        busy;
   logic [2:0]  cur_ratio;
   logic        sel_clk_en;
   logic [15:0] en_cnt;

   modport master (
      output clk_en_vec, ratio_req, ratio_new,
      input  ratio_ack, busy, cur_ratio, sel_clk_en, en_cnt
   );

   modport slave (
      input  clk_en_vec, ratio_req, ratio_new,
      output ratio_ack, busy, cur_ratio, sel_clk_en, en_cnt
   );
endinterface

// File: rtl/clk_ratio_sel.sv
// Glitch-free runtime selector of one osc_clk divider enable, switching ratios
// via drain / guard / align under a req/ack handshake, with a delivered-pulse counter.
module clk_ratio_sel #(
   parameter int unsigned GUARD_CYCLES = 2,
   parameter logic [2:0]  RST_RATIO    = 3'b000
) (
   input logic            osc_clk,
   input logic            pad_cpu_rst,
   clk_ratio_sel_if.slave bus
);
   typedef enum logic [1:0] {IDLE, DRAIN, GUARD, ALIGN} state_t;

   localparam logic       NO_GUARD   = (GUARD_CYCLES == 32'd0);
   localparam logic [3:0] GUARD_LOAD = NO_GUARD ? 4'd0 : 4'(GUARD_CYCLES - 32'd1);

   state_t      state, state_nxt;
   logic [2:0]  cur_ratio_q, pending_q, pending_nxt;
   logic [3:0]  guard_q, guard_nxt;
   logic        req_prev_q;
   logic        ack_q, ack_nxt;
   logic [15:0] cnt_q;
   logic        sel;
   logic        align_hit;
   logic        accept;

   assign accept = bus.ratio_req & ~req_prev_q;

   always_comb begin
      state_nxt   = state;
      pending_nxt = pending_q;
      guard_nxt   = guard_q;
      ack_nxt     = 1'b0;
      sel         = 1'b0;
      align_hit   = 1'b0;
      case (state)
         IDLE: begin
            sel = bus.clk_en_vec[cur_ratio_q];
            if (accept) begin
               if (bus.ratio_new == cur_ratio_q) begin
                  ack_nxt = 1'b1;
               end else begin
                  pending_nxt = bus.ratio_new;
                  state_nxt   = DRAIN;
               end
            end
         end
         DRAIN: begin
            sel = bus.clk_en_vec[cur_ratio_q];
            if (sel) begin
               if (NO_GUARD) begin
                  state_nxt = ALIGN;
               end else begin
                  guard_nxt = GUARD_LOAD;
                  state_nxt = GUARD;
               end
            end
         end
         GUARD: begin
            if (guard_q == 4'd0) begin
               state_nxt = ALIGN;
            end else begin
               guard_nxt = guard_q - 4'd1;
            end
         end
         ALIGN: begin
            sel = bus.clk_en_vec[pending_q];
            if (sel) begin
               align_hit = 1'b1;
               ack_nxt   = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge osc_clk or posedge pad_cpu_rst) begin
      if (pad_cpu_rst) begin
         state       <= IDLE;
         cur_ratio_q <= RST_RATIO;
         pending_q   <= '0;
         guard_q     <= '0;
         req_prev_q  <= 1'b0;
         ack_q       <= 1'b0;
         cnt_q       <= '0;
      end else begin
         state       <= state_nxt;
         pending_q   <= pending_nxt;
         guard_q     <= guard_nxt;
         req_prev_q  <= bus.ratio_req;
         ack_q       <= ack_nxt;
         if (align_hit) begin
            cur_ratio_q <= pending_q;
         end
         // The first new-ratio pulse restarts the count rather than adding to it.
         if (align_hit) begin
            cnt_q <= '0;
         end else if (sel) begin
            cnt_q <= cnt_q + 16'd1;
         end
      end
   end

   assign bus.sel_clk_en = sel;
   assign bus.ratio_ack  = ack_q;
   assign bus.busy       = (state != IDLE);
   assign bus.cur_ratio  = cur_ratio_q;
   assign bus.en_cnt     = cnt_q;
endmodule

// File: tb/tb_clk_ratio_sel.sv
// Scoreboarded directed bench for clk_ratio_sel: a divider model feeds both instances,
// expected acks are queued by the stimulus and consumed by an independent monitor.
module tb_clk_ratio_sel;
   logic osc_clk = 1'b0;
   logic pad_cpu_rst = 1'b1;
   int unsigned cyc = 0;
   int unsigned dph = 0;
   int checks = 0;
   int failures = 0;

   typedef struct {
      int unsigned cyc;
      logic [2:0]  ratio;
      logic [15:0] cnt;
   } exp_t;

   exp_t qa[$];
   exp_t qb[$];

   clk_ratio_sel_if bus_a ();
   clk_ratio_sel_if bus_b ();

   clk_ratio_sel #(.GUARD_CYCLES(2), .RST_RATIO(3'b000)) dut_a (
      .osc_clk(osc_clk), .pad_cpu_rst(pad_cpu_rst), .bus(bus_a)
   );
   clk_ratio_sel #(.GUARD_CYCLES(0), .RST_RATIO(3'b111)) dut_b (
      .osc_clk(osc_clk), .pad_cpu_rst(pad_cpu_rst), .bus(bus_b)
   );

   always #5 osc_clk = ~osc_clk;

   function automatic logic [7:0] div_vec(input int unsigned d);
      logic [7:0] v;
      for (int i = 0; i < 8; i++) v[i] = ((d % (i + 1)) == 0);
      return v;
   endfunction

   // Smallest k >= kmin where the divide-by-div enable fires, given phase d0 at offset 0.
   function automatic int unsigned first_hit(input int unsigned d0, input int unsigned kmin,
                                             input int unsigned div);
      int unsigned k;
      k = kmin;
      while (((d0 + k) % div) != 0) k++;
      return k;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic drain_q(input int budget);
      for (int i = 0; i < budget && (qa.size() != 0 || qb.size() != 0); i++) @(negedge osc_clk);
      checks++;
      if (qa.size() != 0 || qb.size() != 0) begin
         failures++;
         $display("FAIL ack_timeout actual=%0d/%0d expected=0/0", qa.size(), qb.size());
         qa.delete();
         qb.delete();
      end
   endtask

   // Divider model: phase counter over lcm(1..8), held at 0 in reset.
   initial begin
      bus_a.clk_en_vec = 8'hFF;
      bus_b.clk_en_vec = 8'hFF;
      forever begin
         @(posedge osc_clk);
         cyc++;
         #1;
         dph = pad_cpu_rst ? 0 : (dph + 1) % 840;
         bus_a.clk_en_vec = div_vec(dph);
         bus_b.clk_en_vec = div_vec(dph);
      end
   end

   initial begin
      exp_t e;
      forever begin
         @(negedge osc_clk);
         if (bus_a.ratio_ack === 1'b1) begin
            if (qa.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL ack_a_unexpected actual=1 expected=0 (cycle %0d)", cyc);
            end else begin
               e = qa.pop_front();
               check("ack_a_cycle", cyc, e.cyc);
               check("ack_a_ratio", {29'd0, bus_a.cur_ratio}, {29'd0, e.ratio});
               check("ack_a_busy", {31'd0, bus_a.busy}, 32'd0);
               check("ack_a_cnt", {16'd0, bus_a.en_cnt}, {16'd0, e.cnt});
            end
         end
         if (bus_b.ratio_ack === 1'b1) begin
            if (qb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL ack_b_unexpected actual=1 expected=0 (cycle %0d)", cyc);
            end else begin
               e = qb.pop_front();
               check("ack_b_cycle", cyc, e.cyc);
               check("ack_b_ratio", {29'd0, bus_b.cur_ratio}, {29'd0, e.ratio});
               check("ack_b_busy", {31'd0, bus_b.busy}, 32'd0);
               check("ack_b_cnt", {16'd0, bus_b.en_cnt}, {16'd0, e.cnt});
            end
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int unsigned c0, d0, k, kd, ka, a_abs, x, n;
      bus_a.ratio_req = 1'b0; bus_a.ratio_new = 3'd0;
      bus_b.ratio_req = 1'b0; bus_b.ratio_new = 3'd0;

      // Reset values, then DIV1 counting
      repeat (3) @(negedge osc_clk);
      check("rst_a_cur", {29'd0, bus_a.cur_ratio}, 32'd0);
      check("rst_a_busy", {31'd0, bus_a.busy}, 32'd0);
      check("rst_a_ack", {31'd0, bus_a.ratio_ack}, 32'd0);
      check("rst_a_cnt", {16'd0, bus_a.en_cnt}, 32'd0);
      check("rst_b_cur", {29'd0, bus_b.cur_ratio}, 32'd7);
      pad_cpu_rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge osc_clk);
         check("div1_sel", {31'd0, bus_a.sel_clk_en}, 32'd1);
      end
      check("div1_cnt10", {16'd0, bus_a.en_cnt}, 32'd10);

      // Asynchronous reset mid-cycle
      @(posedge osc_clk);
      #2 pad_cpu_rst = 1'b1;
      #1;
      check("async_rst_cnt", {16'd0, bus_a.en_cnt}, 32'd0);
      check("async_rst_cur", {29'd0, bus_a.cur_ratio}, 32'd0);
      check("async_rst_busy", {31'd0, bus_a.busy}, 32'd0);
      @(negedge osc_clk);
      pad_cpu_rst = 1'b0;

      // DIV1 -> DIV4 with two guard cycles
      @(negedge osc_clk);
      bus_a.ratio_new = 3'd3; bus_a.ratio_req = 1'b1;
      c0 = cyc; d0 = dph;
      k = first_hit(d0, 4, 4);
      qa.push_back('{c0 + k + 1, 3'd3, 16'd0});
      @(negedge osc_clk);
      bus_a.ratio_req = 1'b0;
      check("d14_drain_sel", {31'd0, bus_a.sel_clk_en}, 32'd1);
      check("d14_drain_busy", {31'd0, bus_a.busy}, 32'd1);
      for (int j = 2; j <= 3; j++) begin
         @(negedge osc_clk);
         check("d14_guard_sel", {31'd0, bus_a.sel_clk_en}, 32'd0);
         check("d14_guard_busy", {31'd0, bus_a.busy}, 32'd1);
      end
      for (int unsigned j = 4; j <= k; j++) begin
         @(negedge osc_clk);
         check("d14_align_sel", {31'd0, bus_a.sel_clk_en}, {31'd0, j == k});
      end
      for (int j = 1; j <= 5; j++) begin
         @(negedge osc_clk);
         if (j <= 4) check("d14_post_sel", {31'd0, bus_a.sel_clk_en}, {31'd0, j == 4});
      end
      check("d14_post_cnt", {16'd0, bus_a.en_cnt}, 32'd1);
      drain_q(20);

      // DIV8 -> DIV3 with no guard window
      @(negedge osc_clk);
      bus_b.ratio_new = 3'd2; bus_b.ratio_req = 1'b1;
      c0 = cyc; d0 = dph;
      kd = first_hit(d0, 1, 8);
      ka = first_hit(d0, kd + 1, 3);
      qb.push_back('{c0 + ka + 1, 3'd2, 16'd0});
      for (int unsigned j = 1; j <= ka; j++) begin
         @(negedge osc_clk);
         if (j == 1) bus_b.ratio_req = 1'b0;
         check("d83_sel", {31'd0, bus_b.sel_clk_en}, {31'd0, (j == kd) || (j == ka)});
         check("d83_busy", {31'd0, bus_b.busy}, 32'd1);
      end
      drain_q(20);

      // Second rising edge while busy is ignored; held request does not retrigger
      @(negedge osc_clk);
      bus_a.ratio_new = 3'd5; bus_a.ratio_req = 1'b1;
      c0 = cyc; d0 = dph;
      kd = first_hit(d0, 1, 4);
      ka = first_hit(d0, kd + 3, 6);
      a_abs = c0 + ka;
      qa.push_back('{a_abs + 1, 3'd5, 16'd0});
      @(negedge osc_clk);
      bus_a.ratio_req = 1'b0;
      @(negedge osc_clk);
      bus_a.ratio_new = 3'd1; bus_a.ratio_req = 1'b1;
      check("edge_busy", {31'd0, bus_a.busy}, 32'd1);
      repeat (ka - 1) @(negedge osc_clk);
      repeat (20) @(negedge osc_clk);
      check("edge_cur", {29'd0, bus_a.cur_ratio}, 32'd5);
      check("edge_idle", {31'd0, bus_a.busy}, 32'd0);
      drain_q(5);

      // Same-ratio request at DIV6: immediate ack, count kept
      bus_a.ratio_req = 1'b0;
      x = cyc;
      @(negedge osc_clk);
      bus_a.ratio_new = 3'd5; bus_a.ratio_req = 1'b1;
      n = (x + 1 - a_abs) / 6;
      qa.push_back('{x + 2, 3'd5, 16'(n)});
      for (int j = 0; j < 3; j++) begin
         @(negedge osc_clk);
         check("same_busy", {31'd0, bus_a.busy}, 32'd0);
      end
      bus_a.ratio_req = 1'b0;
      drain_q(5);

      // DIV6 -> DIV1, then run the counter through its wrap
      @(negedge osc_clk);
      bus_a.ratio_new = 3'd0; bus_a.ratio_req = 1'b1;
      c0 = cyc; d0 = dph;
      kd = first_hit(d0, 1, 6);
      qa.push_back('{c0 + kd + 4, 3'd0, 16'd0});
      repeat (kd + 4) @(negedge osc_clk);
      bus_a.ratio_req = 1'b0;
      repeat (65535) @(negedge osc_clk);
      check("wrap_ffff", {16'd0, bus_a.en_cnt}, 32'h0000_FFFF);
      @(negedge osc_clk);
      check("wrap_zero", {16'd0, bus_a.en_cnt}, 32'd0);
      drain_q(5);

      // Reset while in GUARD discards the switch
      bus_a.ratio_new = 3'd7; bus_a.ratio_req = 1'b1;
      @(negedge osc_clk);
      check("mid_drain_busy", {31'd0, bus_a.busy}, 32'd1);
      @(negedge osc_clk);
      check("mid_guard_sel", {31'd0, bus_a.sel_clk_en}, 32'd0);
      check("mid_guard_busy", {31'd0, bus_a.busy}, 32'd1);
      #2 pad_cpu_rst = 1'b1;
      #1;
      bus_a.ratio_req = 1'b0;
      check("mid_rst_busy", {31'd0, bus_a.busy}, 32'd0);
      check("mid_rst_cur", {29'd0, bus_a.cur_ratio}, 32'd0);
      check("mid_rst_ack", {31'd0, bus_a.ratio_ack}, 32'd0);
      @(negedge osc_clk);
      pad_cpu_rst = 1'b0;
      repeat (20) @(negedge osc_clk);
      check("mid_after_cur", {29'd0, bus_a.cur_ratio}, 32'd0);
      check("mid_after_busy", {31'd0, bus_a.busy}, 32'd0);
      check("mid_after_b_cur", {29'd0, bus_b.cur_ratio}, 32'd7);
      drain_q(5);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
